// File: rtl/dual_issue_fetch_queue_if.sv
// Fetch/decode bundle of the dual-issue fetch queue: the fetch push pair, the hazard
// stall/flush controls, and the registered decode-lane outputs.
interface dual_issue_fetch_queue_if #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  // push_ready depends only on registered occupancy; a lane-1 push is taken on any edge
  // where push_valid1 & push_ready, lane 2 additionally needs push_valid2, and a push
  // offered while push_ready=0 is dropped rather than held.
  logic                    push_valid1;
  logic [DATA_WIDTH-1:0]   push_instr1;
  logic [ADDR_WIDTH-1:0]   push_pc1;
  logic                    push_valid2;
  logic [DATA_WIDTH-1:0]   push_instr2;
  logic [ADDR_WIDTH-1:0]   push_pc2;
  logic                    push_ready;
  logic                    StallDecode1;
  logic                    StallDecode2;
  logic                    FlushDecode1;
  logic                    FlushDecode2;
  logic [DATA_WIDTH-1:0]   InstrD1;
  logic [ADDR_WIDTH-1:0]   PCD1;
  logic                    ValidD1;
  logic [DATA_WIDTH-1:0]   InstrD2;
  logic [ADDR_WIDTH-1:0]   PCD2;
  logic                    ValidD2;
  logic [$clog2(DEPTH):0]  count;

  modport master (
    output push_valid1, push_instr1, push_pc1, push_valid2, push_instr2, push_pc2,
    output StallDecode1, StallDecode2, FlushDecode1, FlushDecode2,
    input  push_ready, InstrD1, PCD1, ValidD1, InstrD2, PCD2, ValidD2, count
  );

  modport slave (
    input  push_valid1, push_instr1, push_pc1, push_valid2, push_instr2, push_pc2,
    input  StallDecode1, StallDecode2, FlushDecode1, FlushDecode2,
    output push_ready, InstrD1, PCD1, ValidD1, InstrD2, PCD2, ValidD2, count
  );
endinterface

// File: rtl/dual_issue_fetch_queue.sv
// Circular instruction buffer between dual-lane fetch and the two decode-lane registers;
// pushes up to two instructions per cycle and loads the two oldest into decode.
module dual_issue_fetch_queue #(
  parameter int                    DEPTH      = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h00000013
) (
  input logic                    clk,
  input logic                    rst_n,
  dual_issue_fetch_queue_if.slave fq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 2);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);

  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem    [DEPTH];

  logic [PTR_W-1:0]      rd_ptr, wr_ptr, rd_ptr1, wr_ptr1;
  logic [CNT_W-1:0]      count_q, n_push, n_pop;
  logic [DATA_WIDTH-1:0] instr_d1, instr_d2;
  logic [ADDR_WIDTH-1:0] pc_d1, pc_d2;
  logic                  valid_d1, valid_d2;
  logic                  stall, flush, push_ready, push_one, push_two;

  // In-order issue: a stall on either lane freezes both; flush on either clears both.
  always_comb begin
    stall      = fq.StallDecode1 | fq.StallDecode2;
    flush      = fq.FlushDecode1 | fq.FlushDecode2;
    push_ready = (count_q <= READY_MAX);
    push_one   = push_ready & fq.push_valid1;
    push_two   = push_one & fq.push_valid2;
    n_push     = push_two ? TWO : (push_one ? ONE : '0);
    n_pop      = '0;
    if (!stall) begin
      if (count_q >= TWO)      n_pop = TWO;
      else if (count_q == ONE) n_pop = ONE;
    end
    rd_ptr1    = rd_ptr + PTR_W'(1);
    wr_ptr1    = wr_ptr + PTR_W'(1);
  end

  // Storage needs no reset: occupancy and pointers alone decide what is readable.
  always_ff @(posedge clk) begin
    if (push_one && !flush) begin
      instr_mem[wr_ptr] <= fq.push_instr1;
      pc_mem[wr_ptr]    <= fq.push_pc1;
    end
    if (push_two && !flush) begin
      instr_mem[wr_ptr1] <= fq.push_instr2;
      pc_mem[wr_ptr1]    <= fq.push_pc2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      valid_d1 <= 1'b0;
      valid_d2 <= 1'b0;
      instr_d1 <= NOP_INSTR;
      instr_d2 <= NOP_INSTR;
      pc_d1    <= '0;
      pc_d2    <= '0;
    end else if (flush) begin
      count_q  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      valid_d1 <= 1'b0;
      valid_d2 <= 1'b0;
      instr_d1 <= NOP_INSTR;
      instr_d2 <= NOP_INSTR;
      pc_d1    <= '0;
      pc_d2    <= '0;
    end else begin
      count_q <= count_q + n_push - n_pop;
      wr_ptr  <= wr_ptr + PTR_W'(n_push);
      rd_ptr  <= rd_ptr + PTR_W'(n_pop);
      if (!stall) begin
        // Loads come from entries written on earlier edges only; no fetch-to-decode bypass.
        if (count_q >= ONE) begin
          valid_d1 <= 1'b1;
          instr_d1 <= instr_mem[rd_ptr];
          pc_d1    <= pc_mem[rd_ptr];
        end else begin
          valid_d1 <= 1'b0;
          instr_d1 <= NOP_INSTR;
          pc_d1    <= '0;
        end
        if (count_q >= TWO) begin
          valid_d2 <= 1'b1;
          instr_d2 <= instr_mem[rd_ptr1];
          pc_d2    <= pc_mem[rd_ptr1];
        end else begin
          valid_d2 <= 1'b0;
          instr_d2 <= NOP_INSTR;
          pc_d2    <= '0;
        end
      end
    end
  end

  assign fq.push_ready = push_ready;
  assign fq.count      = count_q;
  assign fq.InstrD1    = instr_d1;
  assign fq.PCD1       = pc_d1;
  assign fq.ValidD1    = valid_d1;
  assign fq.InstrD2    = instr_d2;
  assign fq.PCD2       = pc_d2;
  assign fq.ValidD2    = valid_d2;
endmodule

// File: doc/dual_issue_fetch_queue.md
Name: dual_issue_fetch_queue

Overview:
- Instruction buffer between the dual-lane fetch stage and the two decode lanes of the superscalar core.
- Accepts up to two in-order instructions per cycle from fetch and holds them in a circular queue.
- Presents the two oldest instructions to the decode-lane registers.
- Consumes the StallDecode1/2 and FlushDecode1/2 controls produced by the hazard logic, so it is the receiving end of the stall/flush interface.

Parameters:
- DEPTH, 8, queue entries; power of two, minimum 4.
- DATA_WIDTH, 32, instruction width.
- ADDR_WIDTH, 32, PC width.
- NOP_INSTR, 32'h00000013, instruction driven on an invalid lane (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- push_valid1  in  1  fetch lane 1 (older) instruction valid.
- push_instr1  in  DATA_WIDTH  lane 1 instruction.
- push_pc1  in  ADDR_WIDTH  lane 1 PC.
- push_valid2  in  1  fetch lane 2 (younger) instruction valid; meaningful only when push_valid1=1.
- push_instr2  in  DATA_WIDTH  lane 2 instruction.
- push_pc2  in  ADDR_WIDTH  lane 2 PC.
- push_ready  out  1  combinational; 1 when free entries >= 2.
- StallDecode1  in  1  hazard stall, lane 1.
- StallDecode2  in  1  hazard stall, lane 2.
- FlushDecode1  in  1  hazard flush, lane 1.
- FlushDecode2  in  1  hazard flush, lane 2.
- InstrD1  out  DATA_WIDTH  registered decode lane 1 instruction.
- PCD1  out  ADDR_WIDTH  registered decode lane 1 PC.
- ValidD1  out  1  decode lane 1 holds a real instruction.
- InstrD2  out  DATA_WIDTH  registered decode lane 2 instruction.
- PCD2  out  ADDR_WIDTH  registered decode lane 2 PC.
- ValidD2  out  1  decode lane 2 holds a real instruction.
- count  out  $clog2(DEPTH)+1  registered queue occupancy.

Behaviour:
Reset (rst_n low, asynchronous):
- count=0; read and write pointers = 0.
- ValidD1/2=0; InstrD1/2=NOP_INSTR; PCD1/2=0.
- Reset asserted mid-operation discards all contents immediately.

Control signals:
- stall = StallDecode1 | StallDecode2. Lanes issue in order, so a stall on either lane freezes both.
- flush = FlushDecode1 | FlushDecode2.

Push:
- Accepted only when push_ready=1.
- Number pushed = push_valid1 + (push_valid1 & push_valid2).
- push_valid2 without push_valid1 is ignored.
- Lane 1 is written at wr_ptr, lane 2 at wr_ptr+1. Pointers wrap modulo DEPTH.
- Push while push_ready=0 is dropped; the queue is unchanged.

Pop (decode load), evaluated on occupancy before the edge:
- No stall and count>=2: lane 1 loads head, lane 2 loads head+1, pop 2, ValidD1=ValidD2=1.
- No stall and count==1: lane 1 loads head, ValidD2=0, InstrD2=NOP_INSTR, pop 1.
- No stall and count==0: both lanes invalid with NOP_INSTR, pop 0.
- stall=1: InstrD/PCD/ValidD hold, pop 0; pushes are still accepted.

Count and latency:
- count_next = count + pushed - popped. Simultaneous push and pop is legal. Full-queue wrap must be exact.
- No bypass path: an instruction pushed at edge k appears on decode outputs at edge k+1 at the earliest.

Flush (priority over stall and push):
- count=0, pointers=0, ValidD1/2=0, InstrD1/2=NOP_INSTR.
- Any same-cycle push is discarded.

Other rules:
- Simultaneous stall and flush: flush wins.
- push_ready is derived from the registered count only, with no dependence on same-cycle pop.
- Invalid lanes always present NOP_INSTR so decode produces no side effects.

Test Plan:
1. Reset, then push pair (0x00500093 @PC 0x0, 0x00A00113 @PC 0x4) in cycle 0. Required: count=2 after edge 0; after edge 1 ValidD1=ValidD2=1 with matching instr/PC; count=0.
2. Push single 0x00100193 @0x8, no stall. Required: next edge ValidD1=1, PCD1=0x8, ValidD2=0, InstrD2=0x00000013.
3. Hold StallDecode2=1 for 3 cycles while pushing pairs. Required: decode outputs frozen; count rises 2,4,6; push_ready falls to 0 at count=7 or 8. With DEPTH=8 a further push at count=7 is dropped.
4. Fill to count=8, then release stall and push continuously. Required: pops of 2 per cycle; pointers wrap past entry 7; PCs on decode remain strictly consecutive with none lost or duplicated.
5. With count=5 and ValidD1/2=1, assert FlushDecode1 together with StallDecode1 and a push pair. Required next edge: count=0, ValidD1/2=0, InstrD1/2=0x00000013, pushed pair absent.
6. Drop rst_n asynchronously mid-cycle with count=3. Required: outputs reach reset values before the next clk edge; first push after release appears as in scenario 1.
